instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Fetch stage of the single-issue RV32I core. Sits directly upstream of instructionMemory.
//  - Owns the PC and drives the combinational instruction-memory address.
//  - Captures the returned word into a valid/ready output register for decode.
//  - Applies redirects from execute.
//  - Stops fetching once the halt word (unimp) is fetched.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  HALT_WORD  32'hc000_1073  encoding that stops fetch (unimp)
// PORTS
//  clk           in   1   core clock, all state on rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  imem_addr     out  32  byte address to instruction memory (= pc)
//  imem_rdata    in   32  instruction word, combinational from imem_addr same cycle
//  out_valid     out  1   out_instr/out_pc hold a fetched instruction
//  out_ready     in   1   decode accepts this cycle when out_valid && out_ready
//  out_instr     out  32  fetched instruction
//  out_pc        out  32  address of out_instr
//  redirect_vld  in   1   execute requests PC change (taken branch/jump)
//  redirect_pc   in   32  target; bits [1:0] ignored (forced 2'b00)
//  halted        out  1   halt word delivered to decode, fetch stopped
//  perf_fetch    out  32  count of accepted instructions (see CONFIGURATION)
//  perf_stall    out  32  count of stall cycles (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0), effective immediately:
//   - pc=RESET_PC, state=RUN, out_valid=0, out_instr=0, out_pc=0, halted=0, counters=0.
//  imem_addr = pc, purely combinational. Latency: 1 cycle, address -> out_* registered.
//  load = (state==RUN) && (!out_valid || out_ready).
//  Priority per edge:
//   1. redirect_vld:
//      - pc <= {redirect_pc[31:2],2'b00}; out_valid <= 0.
//      - state <= RUN, from RUN or DRAIN; clears halted.
//      - Wins over load and out_ready in the same cycle; flushes the held wrong-path word.
//   2. load:
//      - out_instr <= imem_rdata; out_pc <= pc; out_valid <= 1; pc <= pc+4.
//      - pc wraps modulo 2^32.
//      - If imem_rdata==HALT_WORD: state <= DRAIN, pc not incremented.
//   3. Else if out_valid && out_ready (DRAIN only): out_valid <= 0.
//   4. Otherwise hold all.
//  Stall: out_valid && !out_ready -> out_* and pc hold, no fetch.
//  States:
//   - RUN: fetching.
//   - DRAIN: no fetch, pc frozen at the halt word's address.
//   - Transitions: RUN->DRAIN on halt-word load. DRAIN->RUN only on redirect_vld.
//  halted = (state==DRAIN) && !out_valid, registered (set the cycle after decode accepts the halt word).
//  out_* change only on load or redirect; stable while out_valid && !out_ready.
// CONFIGURATION
//  Macro IFETCH_PERF_EN.
//  Defined:
//   - perf_fetch += 1 on each out_valid && out_ready && !redirect_vld.
//   - perf_stall += 1 on each out_valid && !out_ready.
//   - Both wrap at 2^32. Both reset to 0.
//  Undefined:
//   - No counter flops.
//   - perf_fetch and perf_stall are tied to 32'h0. Ports are always present.
// STRUCTURE
//  Shared package core_pkg:
//   - XLEN=32, INSTR_W=32.
//   - HALT_WORD constant.
//   - Fetch state encoding (RUN=1'b0, DRAIN=1'b1).
//  Single module, no sub-modules.
//  The output register and PC update are one always block; counters are in an `ifdef IFETCH_PERF_EN block.
// TESTING
//  Bench instantiates instruction_fetch + instructionMemory with a preloaded image.
//  1. Reset release, out_ready=1, sequential code:
//     - out_pc = 0x0, 0x4, 0x8 on consecutive cycles; out_valid=1 from the first edge after reset.
//  2. out_ready=0 for 3 cycles while out_pc=0x8:
//     - out_pc/out_instr hold 0x8; imem_addr holds 0xC.
//     - With IFETCH_PERF_EN: perf_stall=3.
//  3. redirect_vld=1, redirect_pc=0x43, out_ready=0, same cycle:
//     - Next cycle: out_valid=0, imem_addr=0x40.
//     - Following cycle: out_pc=0x40.
//  4. Halt word at 0x10:
//     - out_pc=0x10 presented; no address beyond 0x10 is driven; halted=1 the cycle after acceptance.
//     - Then redirect to 0x20: halted=0, fetch resumes at 0x20.
//  5. rst_n pulsed low mid-stream (out_valid=1, pc=0x18):
//     - out_valid=0 and imem_addr=0x0 immediately, without a clock edge.
//  6. IFETCH_PERF_EN defined, 5 acceptances plus 1 redirect flush -> perf_fetch=5.
//     Undefined -> perf_fetch=perf_stall=0 throughout.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core.
//   XLEN / INSTR_W : data path and instruction widths
//   HALT_WORD      : unimp encoding; the fetch stage stops after fetching it
//   fetch_state_e  : fetch stage state encoding (RUN = fetching, DRAIN = stopped)
package core_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] HALT_WORD = 32'hc000_1073;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage of the single-issue RV32I core.
// Owns the PC, drives the instruction-memory address combinationally, and
// captures the returned word into a valid/ready output register for decode.
// Redirects from execute replace the PC and flush the held word. Fetch stops
// once the halt word has been fetched, and only a redirect restarts it.
//
// Ports:
//   clk, rst_n                 clock; asynchronous active-low reset
//   imem_addr  (out)           byte address to instruction memory (= pc)
//   imem_rdata (in)            instruction word for imem_addr, same cycle
//   out_valid/out_ready        decode handshake
//   out_instr/out_pc (out)     fetched instruction and its address
//   redirect_vld/redirect_pc   PC change from execute; low two bits ignored
//   halted     (out)           halt word delivered to decode, fetch stopped
//   perf_fetch/perf_stall      performance counters
//
// Handshake: a word transfers to decode on a rising edge where
// out_valid && out_ready. While out_valid && !out_ready the output register
// and pc hold. A redirect in the same cycle takes priority and discards the
// held word, so it is never counted as transferred.
//
// Build option: define IFETCH_PERF_EN to build the counters; otherwise
// perf_fetch and perf_stall are tied to zero.
module instruction_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = core_pkg::HALT_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_vld,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall
);

  fetch_state_e state, state_d;
  logic [31:0]  pc, pc_d;
  logic         out_valid_d;
  logic [31:0]  out_instr_d, out_pc_d;
  logic         halted_d;
  logic         load;

  // The low two bits of a redirect target are forced to zero.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign imem_addr = pc;

  always_comb begin
    state_d     = state;
    pc_d        = pc;
    out_valid_d = out_valid;
    out_instr_d = out_instr;
    out_pc_d    = out_pc;
    load        = (state == RUN) && (!out_valid || out_ready);

    if (redirect_vld) begin
      pc_d        = {redirect_pc[31:2], 2'b00};
      out_valid_d = 1'b0;
      state_d     = RUN;
    end else if (load) begin
      out_instr_d = imem_rdata;
      out_pc_d    = pc;
      out_valid_d = 1'b1;
      if (imem_rdata == HALT_WORD) begin
        // pc stays on the halt word's address while draining.
        state_d = DRAIN;
      end else begin
        pc_d = pc + 32'd4;
      end
    end else if (out_valid && out_ready) begin
      // Only reachable in DRAIN: decode takes the halt word.
      out_valid_d = 1'b0;
    end

    // Registered from next-state values so it rises the cycle after decode
    // takes the halt word and drops with the redirect that restarts fetch.
    halted_d = (state_d == DRAIN) && !out_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      halted    <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      out_valid <= out_valid_d;
      out_instr <= out_instr_d;
      out_pc    <= out_pc_d;
      halted    <= halted_d;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt, stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      // A word flushed by a redirect is not a delivered instruction.
      if (out_valid && out_ready && !redirect_vld) fetch_cnt <= fetch_cnt + 32'd1;
      if (out_valid && !out_ready)                 stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_fetch = fetch_cnt;
  assign perf_stall = stall_cnt;
`else
  assign perf_fetch = 32'h0;
  assign perf_stall = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch with a behavioural instruction memory.
// Directed sequence: sequential fetch, stall, redirect flush, halt and
// restart, asynchronous reset mid-stream.
module tb_instruction_fetch;

  localparam logic [31:0] HALT = 32'hc000_1073;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        halted;
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];

  instruction_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .halted       (halted),
    .perf_fetch   (perf_fetch),
    .perf_stall   (perf_stall)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction memory image ----------------
  // addi x0,x0,<addr> at every word, except the halt word at 0x10.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return HALT;
    return 32'h0000_0013 | (a << 20);
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [31:0] a);
    exp_q.push_back({a, mem_word(a)});
  endtask

  // ---------------- scoreboard monitor ----------------
  // Sampled on the falling edge: a transfer happens at the next rising edge
  // when valid && ready and no redirect flushes the word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !redirect_vld) begin
      logic [63:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_transfer: got pc 0x%08h instr 0x%08h, expected none",
                 out_pc, out_instr);
      end else begin
        e = exp_q.pop_front();
        if ({out_pc, out_instr} !== e) begin
          errors++;
          $display("FAIL transfer: got pc 0x%08h instr 0x%08h expected pc 0x%08h instr 0x%08h",
                   out_pc, out_instr, e[63:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n        = 1'b0;
    out_ready    = 1'b1;
    redirect_vld = 1'b0;
    redirect_pc  = 32'h0;

    // Words expected to reach decode, in order; 0x8 is dropped while stalled
    // and 0x40 is flushed by a redirect.
    expect_word(32'h00);
    expect_word(32'h04);
    expect_word(32'h10);
    expect_word(32'h20);
    expect_word(32'h24);

    #12;
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);
    check("reset_imem_addr", imem_addr, 32'h0);
    check("reset_out_pc", out_pc, 32'h0);
    check("reset_out_instr", out_instr, 32'h0);
    check("reset_halted", {31'b0, halted}, 32'h0);
    check("reset_perf_fetch", perf_fetch, 32'h0);
    check("reset_perf_stall", perf_stall, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // 1. sequential fetch
    step();  // E1
    check("seq_valid_first_edge", {31'b0, out_valid}, 32'h1);
    check("seq_pc0", out_pc, 32'h0);
    step();  // E2
    check("seq_pc4", out_pc, 32'h4);
    step();  // E3
    check("seq_pc8", out_pc, 32'h8);

    // 2. stall three cycles while 0x8 is held
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();  // E4..E6
      check("stall_out_pc", out_pc, 32'h8);
      check("stall_out_instr", out_instr, mem_word(32'h8));
      check("stall_imem_addr", imem_addr, 32'hC);
      check("stall_valid", {31'b0, out_valid}, 32'h1);
    end
`ifdef IFETCH_PERF_EN
    check("perf_stall_3", perf_stall, 32'd3);
`else
    check("perf_stall_off", perf_stall, 32'h0);
`endif

    // 3. redirect with a misaligned target while stalled
    redirect_vld = 1'b1;
    redirect_pc  = 32'h43;
    step();  // E7
    check("redir_valid_cleared", {31'b0, out_valid}, 32'h0);
    check("redir_imem_addr", imem_addr, 32'h40);
    redirect_vld = 1'b0;
    out_ready    = 1'b1;
    step();  // E8
    check("redir_out_pc", out_pc, 32'h40);
    check("redir_out_valid", {31'b0, out_valid}, 32'h1);

    // Redirect while 0x40 is offered: the word is flushed, not delivered.
    redirect_vld = 1'b1;
    redirect_pc  = 32'h10;
    step();  // E9
    check("flush_valid_cleared", {31'b0, out_valid}, 32'h0);
    redirect_vld = 1'b0;

    // 4. halt word at 0x10
    step();  // E10
    check("halt_out_pc", out_pc, 32'h10);
    check("halt_out_instr", out_instr, HALT);
    check("halt_imem_addr_frozen", imem_addr, 32'h10);
    check("halt_not_yet", {31'b0, halted}, 32'h0);
    step();  // E11: decode took the halt word
    check("halted_set", {31'b0, halted}, 32'h1);
    check("halted_valid_low", {31'b0, out_valid}, 32'h0);
    check("halted_imem_addr", imem_addr, 32'h10);
    step();  // E12
    check("halted_hold", {31'b0, halted}, 32'h1);
    check("halted_no_fetch", {31'b0, out_valid}, 32'h0);
    check("halted_addr_hold", imem_addr, 32'h10);

    redirect_vld = 1'b1;
    redirect_pc  = 32'h20;
    step();  // E13
    check("restart_halted_clear", {31'b0, halted}, 32'h0);
    check("restart_imem_addr", imem_addr, 32'h20);
    redirect_vld = 1'b0;
    step();  // E14
    check("restart_out_pc", out_pc, 32'h20);
    step();  // E15
    step();  // E16
    check("resume_out_pc", out_pc, 32'h28);
    check("resume_imem_addr", imem_addr, 32'h2C);

    // 6. counters: transfers of 0x0, 0x4, 0x10, 0x20, 0x24
`ifdef IFETCH_PERF_EN
    check("perf_fetch_5", perf_fetch, 32'd5);
    check("perf_stall_4", perf_stall, 32'd4);
`else
    check("perf_fetch_off", perf_fetch, 32'h0);
    check("perf_stall_off_end", perf_stall, 32'h0);
`endif

    // 5. asynchronous reset mid-stream, between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'h0);
    check("async_rst_imem_addr", imem_addr, 32'h0);
    check("async_rst_perf_fetch", perf_fetch, 32'h0);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending transfers, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
